// File: rtl/dmem_portb_arbiter.sv
// Round-robin arbiter sharing data-memory port B among NREQ bulk-write requesters.
// Latency: grant registered one cycle after req; accepted beats pass to port B combinationally.
// Backpressure: ready drops while core_we is high; optional address checking via DMEM_ARB_ADDR_CHECK_EN.
module dmem_portb_arbiter #(
  parameter int NREQ      = 2,
  parameter int DEPTH     = 12,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      valid,
  input  logic [NREQ-1:0]      last,
  input  logic [NREQ*32-1:0]   addr,
  input  logic [NREQ*32-1:0]   din,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      ready,
  input  logic                 core_we,
  output logic [31:0]          addr_b,
  output logic [31:0]          din_b,
  output logic                 we_b,
  output logic                 busy,
  output logic                 err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [IW-1:0]   win, win_nxt;   // index of the granted requester
  logic [IW-1:0]   ptr, ptr_nxt;   // last requester served
  logic [CW-1:0]   cnt, cnt_nxt;   // beats accepted in the current grant

  logic [IW-1:0]   pick;
  logic            pick_vld;
  logic            sel_req, sel_valid, sel_last;
  logic [31:0]     sel_addr, sel_din;
  logic            accept, wr, addr_bad;
  logic            burst_done;

  // Round-robin pick: first requesting index after ptr, wrapping
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!pick_vld && req[(int'(ptr) + i) % NREQ]) begin
        pick_vld = 1'b1;
        pick     = IW'((int'(ptr) + i) % NREQ);
      end
    end
  end

  // Select the granted requester's beat signals
  always_comb begin
    sel_req   = 1'b0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_addr  = '0;
    sel_din   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IW'(i)) begin
        sel_req   = req[i];
        sel_valid = valid[i];
        sel_last  = last[i];
        sel_addr  = addr[32*i +: 32];
        sel_din   = din[32*i +: 32];
      end
    end
  end

`ifdef DMEM_ARB_ADDR_CHECK_EN
  localparam logic [31:0] HI_MASK = (DEPTH >= 32) ? 32'h0 : ~((32'h1 << DEPTH) - 32'h1);
  logic err_q;

  // Misaligned or out-of-range beats are consumed but never written
  always_comb begin
    addr_bad = (sel_addr[1:0] != 2'b00) || ((sel_addr & HI_MASK) != 32'h0);
  end

  // Sticky error: set by any rejected beat, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept && addr_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign addr_bad = 1'b0;
  assign err      = 1'b0;
`endif

  // State register: grant, pointer and beat count
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      win   <= '0;
      ptr   <= IW'(NREQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      win   <= win_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs: ready only to the winner, and never while the core stores or reset is high
  always_comb begin
    ready  = (state == GRANT && !core_we && !reset) ? gnt : '0;
    accept = sel_valid && (|(ready & valid));
    wr     = accept && !addr_bad;
    we_b   = wr;
    addr_b = wr ? sel_addr : 32'h0;
    din_b  = wr ? sel_din  : 32'h0;
    busy   = (state != IDLE);
  end

  assign burst_done = ((cnt + CW'(1)) == CW'(MAX_BURST));

  // Next state: arbitrate in IDLE, count beats and detect release in GRANT
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    win_nxt   = win;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = GRANT;
          gnt_nxt   = NREQ'(1) << pick;
          win_nxt   = pick;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          cnt_nxt = cnt + CW'(1);
        end
        if ((accept && (sel_last || burst_done)) || (!sel_req && !sel_valid)) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = win;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Scoreboard bench for dmem_portb_arbiter: directed bursts, expected writes/grants queued up front.
module tb_dmem_portb_arbiter;

  localparam int NREQ = 2;
  localparam int DEPTH = 12;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req, valid, last, gnt, ready;
  logic [NREQ*32-1:0] addr, din;
  logic               core_we = 1'b0;
  logic [31:0]        addr_b, din_b;
  logic               we_b, busy, err;

  logic        req_v  [NREQ] = '{default: 1'b0};
  logic        val_v  [NREQ] = '{default: 1'b0};
  logic        last_v [NREQ] = '{default: 1'b0};
  logic [31:0] addr_v [NREQ] = '{default: 32'h0};
  logic [31:0] din_v  [NREQ] = '{default: 32'h0};

  always_comb begin
    req = '0; valid = '0; last = '0; addr = '0; din = '0;
    for (int i = 0; i < NREQ; i++) begin
      req[i]           = req_v[i];
      valid[i]         = val_v[i];
      last[i]          = last_v[i];
      addr[32*i +: 32] = addr_v[i];
      din[32*i +: 32]  = din_v[i];
    end
  end

  dmem_portb_arbiter #(.NREQ(NREQ), .DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req(req), .valid(valid), .last(last),
    .addr(addr), .din(din), .gnt(gnt), .ready(ready), .core_we(core_we),
    .addr_b(addr_b), .din_b(din_b), .we_b(we_b), .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_pass = 0;

`ifdef DMEM_ARB_ADDR_CHECK_EN
  localparam logic CHK_EN = 1'b1;
`else
  localparam logic CHK_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  logic [63:0] wr_q[$];
  int          gnt_q[$];

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    wr_q.push_back({a, d});
  endtask

  // Monitor: compare every port-B write and every new grant against the queues
  logic [NREQ-1:0] prev_gnt = '0;
  always @(negedge clk) begin
    logic [63:0] e;
    int g;
    if (we_b) begin
      if (wr_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_write: addr_b=0x%0h din_b=0x%0h, expected no write", addr_b, din_b);
      end else begin
        e = wr_q.pop_front();
        chk("addr_b", addr_b, e[63:32]);
        chk("din_b", din_b, e[31:0]);
      end
    end
    if (gnt != '0 && prev_gnt == '0) begin
      if (gnt_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_grant: gnt=0x%0h, expected none", gnt);
      end else begin
        g = gnt_q.pop_front();
        chk("grant_order", 32'(gnt), 32'(1) << g);
      end
    end
    prev_gnt = gnt;
  end

  // Requester driver: n beats at a0+4k / d0+k; mode 0 no last, 1 last every beat, 2 last on final
  task automatic drive(input int r, input int n, input logic [31:0] a0, input logic [31:0] d0,
                       input int mode);
    int t;
    for (int k = 0; k < n; k++) begin
      req_v[r]  = 1'b1;
      val_v[r]  = 1'b1;
      addr_v[r] = a0 + 32'(4 * k);
      din_v[r]  = d0 + 32'(k);
      last_v[r] = (mode == 1) || (mode == 2 && k == n - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (ready[r]) break;
        t++;
        if (t > 100) begin
          chk("ready_timeout", 32'(ready[r]), 32'h1);
          req_v[r] = 1'b0; val_v[r] = 1'b0; last_v[r] = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    req_v[r] = 1'b0; val_v[r] = 1'b0; last_v[r] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_we_b", 32'(we_b), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $finish;
  end

  initial begin
    #1;
    reset_dut();

    // Single 3-beat burst from requester 0
    gnt_q.push_back(0);
    exp_wr(32'h0, 32'hA0); exp_wr(32'h4, 32'hA1); exp_wr(32'h8, 32'hA2);
    fork
      drive(0, 3, 32'h0, 32'hA0, 2);
      begin @(posedge clk); #1; chk("t1_gnt_cycle1", 32'(gnt), 32'h1); end
    join
    chk("t1_gnt_released", 32'(gnt), 32'h0);
    idle(1);
    chk("t1_busy_idle", 32'(busy), 32'h0);

    // Both requesting, last on every beat: 0,1,0,1
    reset_dut();
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
    exp_wr(32'h100, 32'hB0); exp_wr(32'h200, 32'hB8);
    exp_wr(32'h104, 32'hB1); exp_wr(32'h204, 32'hB9);
    fork
      drive(0, 2, 32'h100, 32'hB0, 1);
      drive(1, 2, 32'h200, 32'hB8, 1);
    join
    idle(2);

    // Requester 1 streams 10 beats, forced release every MB=4 beats
    gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0);
    gnt_q.push_back(1); gnt_q.push_back(1);
    exp_wr(32'h300, 32'h30);
    for (int k = 0; k < 4; k++) exp_wr(32'h400 + 32'(4 * k), 32'h40 + 32'(k));
    exp_wr(32'h304, 32'h31);
    for (int k = 4; k < 10; k++) exp_wr(32'h400 + 32'(4 * k), 32'h40 + 32'(k));
    fork
      drive(0, 2, 32'h300, 32'h30, 1);
      drive(1, 10, 32'h400, 32'h40, 2);
    join
    idle(2);

    // core_we stall for 2 cycles; stall must not consume burst budget
    gnt_q.push_back(0);
    for (int k = 0; k < 4; k++) exp_wr(32'h40 + 32'(4 * k), 32'hC0 + 32'(k));
    core_we = 1'b1;
    req_v[0] = 1'b1; val_v[0] = 1'b1; addr_v[0] = 32'h40; din_v[0] = 32'hC0; last_v[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_stall1_ready", 32'(ready), 32'h0);
    chk("t4_stall1_we_b", 32'(we_b), 32'h0);
    chk("t4_stall1_gnt", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_stall2_ready", 32'(ready), 32'h0);
    chk("t4_stall2_we_b", 32'(we_b), 32'h0);
    chk("t4_stall2_gnt", 32'(gnt), 32'h1);
    @(posedge clk); #1;
    core_we = 1'b0;
    drive(0, 4, 32'h40, 32'hC0, 0);
    chk("t4_release_after_4", 32'(gnt), 32'h0);
    idle(2);

    // Reset during the second beat of a burst
    gnt_q.push_back(0);
    exp_wr(32'h80, 32'hD0);
    req_v[0] = 1'b1; val_v[0] = 1'b1; addr_v[0] = 32'h80; din_v[0] = 32'hD0; last_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    addr_v[0] = 32'h84; din_v[0] = 32'hD1;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_we_b_in_reset", 32'(we_b), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    req_v[0] = 1'b0; val_v[0] = 1'b0;
    chk("t5_gnt_after_reset", 32'(gnt), 32'h0);
    chk("t5_busy_after_reset", 32'(busy), 32'h0);
    @(posedge clk); #1;
    chk("t5_gnt_idle", 32'(gnt), 32'h0);
    gnt_q.push_back(1);
    exp_wr(32'h90, 32'hE0);
    fork
      drive(1, 1, 32'h90, 32'hE0, 2);
      begin @(posedge clk); #1; chk("t5_gnt_req1", 32'(gnt), 32'h2); end
    join
    idle(2);

    // Misaligned beat at 0x2 followed by aligned beat at 0x10
    gnt_q.push_back(0);
    if (!CHK_EN) exp_wr(32'h2, 32'hF0);
    exp_wr(32'h10, 32'hF1);
    req_v[0] = 1'b1; val_v[0] = 1'b1; addr_v[0] = 32'h2; din_v[0] = 32'hF0; last_v[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_ready_bad", 32'(ready), 32'h1);
    chk("t6_we_b_bad", 32'(we_b), 32'(!CHK_EN));
    chk("t6_err_before", 32'(err), 32'h0);
    @(posedge clk); #1;
    chk("t6_err_set", 32'(err), 32'(CHK_EN));
    addr_v[0] = 32'h10; din_v[0] = 32'hF1; last_v[0] = 1'b1;
    @(negedge clk);
    chk("t6_we_b_good", 32'(we_b), 32'h1);
    @(posedge clk); #1;
    req_v[0] = 1'b0; val_v[0] = 1'b0; last_v[0] = 1'b0;
    chk("t6_gnt_released", 32'(gnt), 32'h0);
    idle(3);
    chk("t6_err_sticky", 32'(err), 32'(CHK_EN));

    chk("writes_drained", 32'(wr_q.size()), 32'h0);
    chk("grants_drained", 32'(gnt_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
